// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared widths and types for the DSP MAC stream controller
package dsp_mac_pkg;
    localparam int DSP_DATA_W = 32;
    localparam int DSP_ACC_W  = 64;
    localparam int DSP_CNT_W  = 16;

    typedef struct packed {
        logic signed [DSP_DATA_W-1:0] a;
        logic signed [DSP_DATA_W-1:0] b;
        logic signed [DSP_DATA_W-1:0] c;
        logic signed [DSP_DATA_W-1:0] d;
        logic                         first;
        logic                         last;
    } dsp_beat_t;

    typedef struct packed {
        logic signed [DSP_ACC_W-1:0] p;
        logic [DSP_CNT_W-1:0]        count;
    } dsp_res_t;

    typedef enum logic {
        GRP_IDLE  = 1'b0,
        GRP_ACCUM = 1'b1
    } grp_state_t;
endpackage

// File: rtl/dsp_mac_result_fifo.sv
// rtl/dsp_mac_result_fifo.sv - negedge result FIFO holding finished group sums
module dsp_mac_result_fifo
    import dsp_mac_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     push,
    input  dsp_res_t push_data,
    input  logic     pop,
    output dsp_res_t head,
    output logic     full,
    output logic     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    dsp_res_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when a pop frees the slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(negedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dsp_mac_stream_ctrl.sv
// rtl/dsp_mac_stream_ctrl.sv - pre-add/multiply/accumulate pipeline with grouped, buffered results
module dsp_mac_stream_ctrl
    import dsp_mac_pkg::*;
#(
    parameter int DATA_W    = DSP_DATA_W,
    parameter int ACC_W     = DSP_ACC_W,
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = DSP_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    input  logic signed [DATA_W-1:0] C,
    input  logic signed [DATA_W-1:0] D,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_p,
    output logic [CNT_W-1:0]         out_count,
    output logic                     err_restart
);
    dsp_beat_t                in_beat;
    logic                     s1_valid, s1_first, s1_last;
    logic signed [DATA_W:0]   s1_pre;
    logic signed [DATA_W-1:0] s1_b, s1_c;
    logic                     s2_valid, s2_first, s2_last;
    logic signed [ACC_W-1:0]  s2_prod;
    logic signed [DATA_W-1:0] s2_c;
    logic                     s3_valid, s3_last;
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic [CNT_W-1:0]         cnt, cnt_next;
    grp_state_t               state, state_next;
    logic                     err_next, start;
    logic signed [2*DATA_W:0] prod_full;
    logic                     fifo_full, fifo_empty, push, pop, stall, accept;
    dsp_res_t                 head;

    assign in_beat = '{a: A, b: B, c: C, d: D, first: in_first, last: in_last};

    // A finished sum waiting in S3 blocks the whole pipe until the FIFO has room.
    assign pop      = !fifo_empty && out_ready;
    assign stall    = s3_valid && s3_last && fifo_full && !pop;
    assign push     = s3_valid && s3_last && !stall;
    assign in_ready = reset && !stall;
    assign accept   = in_valid && in_ready;

    assign prod_full = s1_b * s1_pre;

    always_ff @(negedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s1_pre   <= (DATA_W+1)'($signed(in_beat.a)) + (DATA_W+1)'($signed(in_beat.d));
            s1_b     <= in_beat.b;
            s1_c     <= in_beat.c;
            s1_first <= in_beat.first;
            s1_last  <= in_beat.last;
            s2_valid <= s1_valid;
            s2_prod  <= ACC_W'(prod_full);
            s2_c     <= s1_c;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s3_valid <= s2_valid;
            s3_last  <= s2_valid && s2_last;
        end
    end

    always_ff @(negedge clk) begin
        if (!reset) begin
            state       <= GRP_IDLE;
            acc         <= '0;
            cnt         <= '0;
            err_restart <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            cnt         <= cnt_next;
            err_restart <= err_next;
        end
    end

    // Any beat arriving with no open group starts one, whatever in_first says.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        err_next   = err_restart;
        start      = (state == GRP_IDLE) || s2_first;
        if (s2_valid && !stall) begin
            if (state == GRP_ACCUM && s2_first) begin
                err_next = 1'b1;
            end
            acc_next   = start ? ACC_W'(s2_c) + s2_prod : acc + s2_prod;
            cnt_next   = start ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
            state_next = s2_last ? GRP_IDLE : GRP_ACCUM;
        end
    end

    dsp_mac_result_fifo #(.DEPTH(OUT_DEPTH)) u_result_fifo (
        .clk       (clk),
        .resetn    (reset),
        .push      (push),
        .push_data ('{p: acc, count: cnt}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_p     = fifo_empty ? '0 : head.p;
    assign out_count = fifo_empty ? '0 : head.count;
endmodule

// File: tb/tb_dsp_mac_stream_ctrl.sv
// tb/tb_dsp_mac_stream_ctrl.sv - self-checking bench with a behavioural group-sum model
module tb_dsp_mac_stream_ctrl;
    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, in_first, in_last;
    logic [31:0] A, B, C, D;
    logic        out_valid, out_ready;
    logic [63:0] out_p;
    logic [15:0] out_count;
    logic        err_restart;

    int          vectors = 0;
    int          miscompares = 0;
    bit          rnd_mode = 0;

    logic [63:0] exp_p[$];
    logic [15:0] exp_c[$];
    bit          open_grp = 0;
    bit          err_exp = 0;
    longint      sum_m = 0;
    logic [15:0] cnt_m = '0;

    dsp_mac_stream_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .in_last     (in_last),
        .A           (A),
        .B           (B),
        .C           (C),
        .D           (D),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_p       (out_p),
        .out_count   (out_count),
        .err_restart (err_restart)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference: each accepted beat contributes B*(A+D); group start adds C; everything wraps at 64 bits.
    task automatic model_beat();
        longint prod;
        prod = longint'($signed(B)) * (longint'($signed(A)) + longint'($signed(D)));
        if (open_grp && in_first) err_exp = 1;
        if (!open_grp || in_first) begin
            sum_m = longint'($signed(C)) + prod;
            cnt_m = 16'd1;
        end else begin
            sum_m = sum_m + prod;
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        end
        open_grp = 1;
        if (in_last) begin
            exp_p.push_back(sum_m);
            exp_c.push_back(cnt_m);
            open_grp = 0;
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(posedge clk);
            #3;
            if (!reset) begin
                exp_p.delete();
                exp_c.delete();
                open_grp = 0;
                err_exp  = 0;
            end else begin
                if (exp_p.size() == 0) begin
                    chk("idle_out_valid", 64'(out_valid), 64'd0);
                end else if (out_valid) begin
                    chk("model_out_p", out_p, exp_p[0]);
                    chk("model_out_count", 64'(out_count), 64'(exp_c[0]));
                end
                if (out_valid && out_ready && exp_p.size() != 0) begin
                    void'(exp_p.pop_front());
                    void'(exp_c.pop_front());
                end
                if (in_valid && in_ready) model_beat();
            end
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input logic f, input logic l);
        A = a; B = b; C = c; D = d;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #2;
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("send_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [63:0] p, input logic [15:0] c);
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                chk(name, out_p, p);
                chk({name, "_count"}, 64'(out_count), 64'(c));
                tick();
                return;
            end
            tick();
        end
        chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int n;
        logic f;
        reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        A = '0; B = '0; C = '0; D = '0;
        out_ready = 1'b0;
        fork
            monitor_loop();
        join_none

        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_p", out_p, 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_err", 64'(err_restart), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();

        out_ready = 1'b1;
        send(32'd5, 32'd2, 32'd3, 32'd4, 1'b1, 1'b1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("latency_edge%0d", e), 64'(out_valid), (e == 3) ? 64'd1 : 64'd0);
        end
        chk("single_p", out_p, 64'd21);
        chk("single_count", 64'(out_count), 64'd1);

        send(32'd5, 32'd2, 32'd3, 32'd4, 1'b1, 1'b0);
        send(32'd1, 32'd3, 32'd99, 32'd1, 1'b0, 1'b1);
        wait_result("group_p", 64'd27, 16'd2);

        send(-32'sd7, 32'd3, 32'd10, 32'd2, 1'b1, 1'b1);
        wait_result("negative_p", -64'sd5, 16'd1);

        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'd0, 32'd0, 32'(i), 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head", out_p, 64'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) wait_result($sformatf("bp_result%0d", i), 64'(i), 16'd1);

        send(32'd1, 32'd1, 32'd0, 32'd1, 1'b1, 1'b0);
        send(32'd0, 32'd0, 32'd7, 32'd0, 1'b1, 1'b1);
        wait_result("restart_p", 64'd7, 16'd1);
        chk("restart_err", 64'(err_restart), 64'd1);

        send(32'd1, 32'd1, 32'd1, 32'd1, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        chk("midrst_err", 64'(err_restart), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b1;
        send(32'd5, 32'd2, 32'd3, 32'd4, 1'b1, 1'b1);
        wait_result("after_reset_p", 64'd21, 16'd1);

        rnd_mode = 1;
        for (int g = 0; g < 200; g++) begin
            n = $urandom_range(1, 8);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 3) == 0) tick();
                f = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 30) == 0);
                send($urandom, $urandom, $urandom, $urandom, f, b == n - 1);
            end
        end
        rnd_mode = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_p.size() == 0) break;
            tick();
        end
        tick();
        chk("drain_pending", 64'(exp_p.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("random_err", 64'(err_restart), 64'(err_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
